// File: rtl/eager_join_register_block.sv
// Eager join: synchronises SIZE elastic inputs into one output, parking early tokens in one-slot registers.
// Define EAGER_JOIN_BYPASS_EN for the 0-latency bypass build; the default is the fully registered build.
module eager_join_register_block #(
  parameter  int SIZE       = 2,
  parameter  int DATA_WIDTH = 32,
  localparam int PW         = (SIZE * DATA_WIDTH > 0) ? SIZE * DATA_WIDTH : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PW-1:0]   ins,
  input  logic [SIZE-1:0] ins_valid,
  output logic [SIZE-1:0] ins_ready,
  output logic [PW-1:0]   outs,
  output logic            outs_valid,
  input  logic            outs_ready
);

  logic [SIZE-1:0] r_full;
  logic [SIZE-1:0] w_load;
  logic            w_fire;

`ifdef EAGER_JOIN_BYPASS_EN
  logic [SIZE-1:0] w_avail;

  // A channel counts as present when parked or when its live token is on the wire.
  assign w_avail    = r_full | ins_valid;
  assign outs_valid = rst & (&w_avail);
  assign w_fire     = outs_valid & outs_ready;
  assign ins_ready  = rst ? ~r_full : '0;
  // Bypassed tokens are consumed by the fire itself, so only park when nothing fires.
  assign w_load     = ins_valid & ins_ready & {SIZE{~w_fire}};
`else
  assign outs_valid = rst & (&r_full);
  assign w_fire     = outs_valid & outs_ready;
  // A full slot may reload in the same cycle it is drained by a fire.
  assign ins_ready  = rst ? (~r_full | {SIZE{w_fire}}) : '0;
  assign w_load     = ins_valid & ins_ready;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= '0;
    end else begin
      r_full <= (r_full & ~{SIZE{w_fire}}) | w_load;
    end
  end

  generate
    if (DATA_WIDTH > 0) begin : g_data
      for (genvar i = 0; i < SIZE; i++) begin : g_ch
        logic [DATA_WIDTH-1:0] r_slot;

        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            r_slot <= '0;
          end else if (w_load[i]) begin
            r_slot <= ins[i*DATA_WIDTH +: DATA_WIDTH];
          end
        end

`ifdef EAGER_JOIN_BYPASS_EN
        assign outs[i*DATA_WIDTH +: DATA_WIDTH] =
          r_full[i] ? r_slot : ins[i*DATA_WIDTH +: DATA_WIDTH];
`else
        assign outs[i*DATA_WIDTH +: DATA_WIDTH] = r_slot;
`endif
      end
    end else begin : g_nodata
      // Control-only join: the data ports carry nothing.
      assign outs = '0;
    end
  endgenerate

endmodule

// File: tb/tb_eager_join_register_block.sv
// Directed bench for eager_join_register_block (SIZE=2, DATA_WIDTH=8); expectations follow the build selected by EAGER_JOIN_BYPASS_EN.
module tb_eager_join_register_block;

  logic        clk;
  logic        rst;
  logic [15:0] ins;
  logic [1:0]  ins_valid;
  logic [1:0]  ins_ready;
  logic [15:0] outs;
  logic        outs_valid;
  logic        outs_ready;

  int n_asserts = 0;
  int n_fail    = 0;
  int fires;
  int first_fire;
  logic [15:0] exp_tok;

  eager_join_register_block #(.SIZE(2), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .outs       (outs),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b0;
    ins        = 16'h0000;
    ins_valid  = 2'b11;
    outs_ready = 1'b0;
    #2;
    chk("rst_ovalid", outs_valid, 1'b0);
    chk("rst_iready", ins_ready, 2'b00);
    step();
    step();
    ins_valid = 2'b00;
    rst       = 1'b1;
    #1;
    chk("rel_iready", ins_ready, 2'b11);
    chk("rel_ovalid", outs_valid, 1'b0);

    // Simultaneous arrival
    step();
    ins        = 16'hB2A1;
    ins_valid  = 2'b11;
    outs_ready = 1'b1;
    #1;
`ifdef EAGER_JOIN_BYPASS_EN
    chk("sim_ovalid", outs_valid, 1'b1);
    chk("sim_outs", outs, 16'hB2A1);
    step();
    ins_valid = 2'b00;
    #1;
    chk("sim_after_ovalid", outs_valid, 1'b0);
    chk("sim_after_iready", ins_ready, 2'b11);
`else
    chk("sim_ovalid0", outs_valid, 1'b0);
    step();
    ins_valid = 2'b00;
    #1;
    chk("sim_ovalid", outs_valid, 1'b1);
    chk("sim_outs", outs, 16'hB2A1);
    chk("sim_iready", ins_ready, 2'b11);
    step();
    #1;
    chk("sim_after_ovalid", outs_valid, 1'b0);
    chk("sim_after_iready", ins_ready, 2'b11);
`endif

    // Staggered arrival: ch0 first, ch1 three cycles later
    step();
    ins       = 16'h0011;
    ins_valid = 2'b01;
    #1;
    chk("stg_ovalid_c1", outs_valid, 1'b0);
    chk("stg_iready_c1", ins_ready, 2'b11);
    step();
    ins_valid = 2'b00;
    #1;
    chk("stg_iready_c2", ins_ready, 2'b10);
    step();
    #1;
    chk("stg_iready_c3", ins_ready, 2'b10);
    step();
    ins       = 16'h2211;
    ins_valid = 2'b10;
    #1;
    chk("stg_iready_c4", ins_ready, 2'b10);
`ifdef EAGER_JOIN_BYPASS_EN
    chk("stg_ovalid_c4", outs_valid, 1'b1);
    chk("stg_outs_c4", outs, 16'h2211);
    step();
    ins_valid = 2'b00;
    #1;
    chk("stg_iready_c5", ins_ready, 2'b11);
    chk("stg_ovalid_c5", outs_valid, 1'b0);
`else
    chk("stg_ovalid_c4", outs_valid, 1'b0);
    step();
    ins_valid = 2'b00;
    #1;
    chk("stg_ovalid_c5", outs_valid, 1'b1);
    chk("stg_outs_c5", outs, 16'h2211);
    chk("stg_iready_c5", ins_ready, 2'b11);
    step();
    #1;
    chk("stg_iready_c6", ins_ready, 2'b11);
    chk("stg_ovalid_c6", outs_valid, 1'b0);
`endif

    // Backpressure with both channels parked
    step();
    outs_ready = 1'b0;
    ins        = 16'h2211;
    ins_valid  = 2'b11;
    step();
    ins = 16'hFFFF;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_outs", outs, 16'h2211);
      chk("bp_ovalid", outs_valid, 1'b1);
      chk("bp_iready", ins_ready, 2'b00);
      step();
    end
    ins_valid  = 2'b00;
    outs_ready = 1'b1;
    #1;
    chk("bp_rel_ovalid", outs_valid, 1'b1);
    chk("bp_rel_outs", outs, 16'h2211);
    step();
    #1;
    chk("bp_nodup_ovalid", outs_valid, 1'b0);
    chk("bp_nodup_iready", ins_ready, 2'b11);

    // Streaming: 100 back-to-back tokens per channel
    fires      = 0;
    first_fire = -1;
    for (int k = 0; k < 102; k++) begin
      step();
      outs_ready = 1'b1;
      if (k < 100) begin
        ins[7:0]  = 8'(k);
        ins[15:8] = 8'(k + 8'h80);
        ins_valid = 2'b11;
      end else begin
        ins_valid = 2'b00;
      end
      #1;
      if (outs_valid) begin
        exp_tok[7:0]  = 8'(fires);
        exp_tok[15:8] = 8'(fires + 8'h80);
        chk("str_token", outs, exp_tok);
        if (first_fire < 0) first_fire = k;
        fires++;
      end
    end
    chk("str_fire_count", fires, 100);
`ifdef EAGER_JOIN_BYPASS_EN
    chk("str_first_fire", first_fire, 0);
`else
    chk("str_first_fire", first_fire, 1);
`endif

    // Reset in the middle of operation
    step();
    ins       = 16'h005A;
    ins_valid = 2'b01;
    #1;
    step();
    ins_valid = 2'b00;
    #1;
    chk("mid_parked_iready", ins_ready, 2'b10);
    rst = 1'b0;
    #1;
    chk("mid_rst_ovalid", outs_valid, 1'b0);
    chk("mid_rst_iready", ins_ready, 2'b00);
    rst = 1'b1;
    #1;
    chk("mid_rel_iready", ins_ready, 2'b11);
    chk("mid_rel_ovalid", outs_valid, 1'b0);
    step();
    ins       = 16'h3300;
    ins_valid = 2'b10;
    #1;
    chk("mid_ch1_ovalid", outs_valid, 1'b0);
    step();
    ins_valid = 2'b00;
    #1;
    chk("mid_ch1_after_ovalid", outs_valid, 1'b0);
    chk("mid_ch1_after_iready", ins_ready, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
